// File: rtl/if_fetch_buffer_pkg.sv
// rtl/if_fetch_buffer_pkg.sv - shared state encodings and sizing helpers for the fetch buffer
package if_fetch_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DROP = 2'd2;

   localparam int unsigned DEF_AW = 32;
   localparam int unsigned DEF_DW = 32;

   localparam logic [31:0] NOP = 32'h0000_0000;

   typedef logic [1:0] fetch_state_t;

   function automatic int unsigned entry_w(input int unsigned aw, input int unsigned dw);
      return aw + dw;
   endfunction

   // One extra bit so a completely full FIFO is distinguishable from empty.
   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/if_fetch_buffer_if.sv
// rtl/if_fetch_buffer_if.sv - PC, instruction-memory and ID-side signals of the fetch stage
interface if_fetch_buffer_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
) ();

   logic          start_i;
   logic [AW-1:0] pc_i;
   logic          stall_o;
   logic          flush_i;
   logic          imem_req_o;
   logic [AW-1:0] imem_addr_o;
   logic          imem_ack_i;
   logic [DW-1:0] imem_data_i;
   logic          valid_o;
   logic          id_ready_i;
   logic [AW-1:0] pc_o;
   logic [DW-1:0] inst_o;

   modport master (
      input  start_i, pc_i, flush_i, imem_ack_i, imem_data_i, id_ready_i,
      output stall_o, imem_req_o, imem_addr_o, valid_o, pc_o, inst_o
   );

   modport slave (
      output start_i, pc_i, flush_i, imem_ack_i, imem_data_i, id_ready_i,
      input  stall_o, imem_req_o, imem_addr_o, valid_o, pc_o, inst_o
   );

endinterface

// File: rtl/if_fetch_buffer_fetch_fifo.sv
// rtl/if_fetch_buffer_fetch_fifo.sv - synchronous DEPTH-entry FIFO holding {pc, instruction} pairs
module fetch_fifo
   import if_fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 64,
   parameter int unsigned CW    = cnt_w(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          i_push,
   input  logic [W-1:0]  i_data,
   input  logic          i_pop,
   input  logic          i_clear,
   output logic [CW-1:0] o_count,
   output logic [W-1:0]  o_head
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_we;
   logic          w_re;

   // Clear wins over both ports so a redirect never leaves a stale entry behind.
   assign w_we = i_push & ~i_clear;
   assign w_re = i_pop  & ~i_clear;

   always_ff @(posedge clk_i) begin
      if (rst_i || i_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_we) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_re) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_we, w_re})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_we) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_count = r_count;
   assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;

   a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
      w_we |-> (r_count != CW'(DEPTH)) || w_re);

   a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
      w_re |-> (r_count != '0));

endmodule

// File: rtl/if_fetch_buffer.sv
// rtl/if_fetch_buffer.sv - fetch stage: one outstanding imem read, results queued for ID
module if_fetch_buffer
   import if_fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = DEF_AW,
   parameter int unsigned DW    = DEF_DW
) (
   input  logic           clk_i,
   input  logic           rst_i,
   if_fetch_buffer_if.master bus
);

   localparam int unsigned EW = entry_w(AW, DW);
   localparam int unsigned CW = cnt_w(DEPTH);

   fetch_state_t  r_state;
   logic [AW-1:0] r_req_pc;

   logic          w_ack_wait;
   logic          w_push;
   logic          w_pop;
   logic          w_valid;
   logic          w_space;
   logic [CW-1:0] w_count;
   logic [EW-1:0] w_head;

   assign w_ack_wait = (r_state == ST_WAIT) & bus.imem_ack_i;
   assign w_push     = w_ack_wait & ~bus.flush_i;
   assign w_valid    = (w_count != '0);
   assign w_pop      = w_valid & bus.id_ready_i & ~bus.flush_i;
   // Space is reserved at issue time, so the matching ack can always push.
   assign w_space    = (w_count < CW'(DEPTH));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= ST_IDLE;
         r_req_pc <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.start_i && !bus.flush_i && w_space) begin
                  r_state  <= ST_WAIT;
                  r_req_pc <= bus.pc_i;
               end
            end
            ST_WAIT: begin
               if (bus.imem_ack_i)   r_state <= ST_IDLE;
               else if (bus.flush_i) r_state <= ST_DROP;
            end
            ST_DROP: begin
               // The killed read still owes us an ack; swallow it before reissuing.
               if (bus.imem_ack_i) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .W     (EW),
      .CW    (CW)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .i_push  (w_push),
      .i_data  ({r_req_pc, bus.imem_data_i}),
      .i_pop   (w_pop),
      .i_clear (bus.flush_i),
      .o_count (w_count),
      .o_head  (w_head)
   );

   assign bus.imem_req_o  = (r_state == ST_WAIT);
   assign bus.imem_addr_o = r_req_pc;
   assign bus.stall_o     = ~(w_ack_wait | bus.flush_i);
   assign bus.valid_o     = w_valid;
   assign bus.pc_o        = w_head[EW-1:DW];
   assign bus.inst_o      = w_valid ? w_head[DW-1:0] : DW'(NOP);

endmodule

// File: tb/tb_if_fetch_buffer.sv
// tb/tb_if_fetch_buffer.sv - randomized scoreboard bench for if_fetch_buffer
module tb_if_fetch_buffer;

   localparam int DEPTH = 4;
   localparam int AW    = 32;
   localparam int DW    = 32;

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [DW-1:0] inst;
   } ent_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   if_fetch_buffer_if #(.AW(AW), .DW(DW)) bus ();

   if_fetch_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int n_total = 0;
   int n_pass  = 0;
   int n_pops  = 0;
   bit chk_en  = 0;

   // Reference model: an outstanding-read record plus a queue of expected entries.
   ent_t          exp_q[$];
   bit            m_busy, m_drop;
   logic [AW-1:0] m_reqpc;
   int            m_cnt, since, lat;

   bit            c_rst, c_start, c_flush, c_ack, c_ready;
   logic [AW-1:0] c_pc;
   logic [DW-1:0] c_data;

   int unsigned p_start, p_flush, p_ready, p_stray, lat_min, lat_max;
   bit k_ready_on_ack, os_flush_wait, os_flush_ack, os_rst_wait, stray_next;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic bit pct(input int unsigned p);
      return $urandom_range(0, 99) < p;
   endfunction

   task automatic apply();
      rst             = c_rst;
      bus.start_i     = c_start;
      bus.pc_i        = c_pc;
      bus.flush_i     = c_flush;
      bus.imem_ack_i  = c_ack;
      bus.imem_data_i = c_data;
      bus.id_ready_i  = c_ready;
   endtask

   // Advance the model by one clock using only the inputs the bench drove.
   task automatic model_update();
      bit            live, push, pop;
      int            cnt_old;
      logic [AW-1:0] pc_old;
      if (c_rst) begin
         m_busy = 0; m_drop = 0; m_reqpc = '0; m_cnt = 0; c_pc = '0;
         exp_q.delete();
         return;
      end
      live    = m_busy && !m_drop && c_ack;
      push    = live && !c_flush;
      pop     = (m_cnt != 0) && c_ready && !c_flush;
      cnt_old = m_cnt;
      pc_old  = c_pc;
      if (c_flush) c_pc = 32'h40 + AW'($urandom_range(0, 63) * 4);
      else if (live) c_pc = c_pc + 4;
      if (c_flush) begin
         m_cnt = 0;
         exp_q.delete();
      end else begin
         m_cnt = m_cnt + int'(push) - int'(pop);
         if (push) exp_q.push_back('{pc: m_reqpc, inst: c_data});
      end
      if (m_busy) begin
         if (c_ack) begin m_busy = 0; m_drop = 0; end
         else if (c_flush) m_drop = 1;
      end else if (c_start && !c_flush && cnt_old < DEPTH) begin
         m_busy = 1; m_drop = 0; m_reqpc = pc_old;
         since = -1;
         lat = $urandom_range(lat_min, lat_max);
      end
   endtask

   task automatic choose_inputs();
      c_rst = 0;
      c_ack = 0;
      if (m_busy) begin
         since++;
         c_ack = (since == lat);
      end else if (stray_next || pct(p_stray)) begin
         c_ack = 1;
      end
      stray_next = 0;
      c_data  = $urandom();
      c_start = pct(p_start);
      c_flush = pct(p_flush);
      if (os_flush_wait && m_busy && !m_drop && !c_ack) begin c_flush = 1; os_flush_wait = 0; end
      if (os_flush_ack && m_busy && !m_drop && c_ack) begin c_flush = 1; os_flush_ack = 0; end
      if (os_rst_wait && m_busy && !m_drop && !c_ack) begin
         c_rst = 1; c_flush = 0; os_rst_wait = 0; stray_next = 1;
      end
      c_ready = k_ready_on_ack ? c_ack : pct(p_ready);
      apply();
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      choose_inputs();
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic knobs(input int unsigned s, input int unsigned f, input int unsigned r,
                        input int unsigned st, input int unsigned lmin, input int unsigned lmax);
      p_start = s; p_flush = f; p_ready = r; p_stray = st; lat_min = lmin; lat_max = lmax;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("imem_req",  64'(bus.imem_req_o),  64'(m_busy && !m_drop));
         chk("imem_addr", 64'(bus.imem_addr_o), 64'(m_reqpc));
         chk("stall",     64'(bus.stall_o),     64'(!((m_busy && !m_drop && c_ack) || c_flush)));
         chk("valid",     64'(bus.valid_o),     64'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            chk("head_pc",   64'(bus.pc_o),   64'(exp_q[0].pc));
            chk("head_inst", 64'(bus.inst_o), 64'(exp_q[0].inst));
            if (c_ready && !c_flush) begin
               void'(exp_q.pop_front());
               n_pops++;
            end
         end else begin
            chk("empty_pc",   64'(bus.pc_o),   64'd0);
            chk("empty_inst", 64'(bus.inst_o), 64'd0);
         end
      end
   end

   initial begin
      knobs(0, 0, 0, 0, 1, 1);
      k_ready_on_ack = 0; os_flush_wait = 0; os_flush_ack = 0; os_rst_wait = 0; stray_next = 0;
      m_busy = 0; m_drop = 0; m_reqpc = '0; m_cnt = 0; since = 0; lat = 1;
      c_rst = 1; c_start = 0; c_flush = 0; c_ack = 0; c_ready = 0; c_pc = '0; c_data = '0;
      apply();
      repeat (3) begin
         @(posedge clk);
         model_update();
      end
      #1;
      chk_en = 1;
      c_rst = 0;
      apply();

      // Single fetch with one-cycle ack latency, then a few more in steady state.
      knobs(100, 0, 100, 0, 1, 1);
      run(12);

      // ID stalled: FIFO fills to DEPTH and requesting stops; then drain in order.
      knobs(100, 0, 0, 0, 1, 1);
      run(20);
      knobs(0, 0, 100, 0, 1, 1);
      run(12);

      // Redirect while the read is outstanding; its late ack must be discarded.
      knobs(100, 0, 100, 0, 3, 3);
      os_flush_wait = 1;
      run(20);

      // Redirect coinciding with the ack.
      knobs(100, 0, 100, 0, 2, 2);
      os_flush_ack = 1;
      run(16);

      // Hold two entries while pushing and popping together across pointer wrap.
      knobs(0, 0, 100, 0, 1, 1);
      run(8);
      knobs(100, 0, 0, 0, 1, 1);
      for (int i = 0; i < 40 && m_cnt < 2; i++) step();
      k_ready_on_ack = 1;
      run(30);
      k_ready_on_ack = 0;

      // Reset during an outstanding read, followed by a stray ack.
      knobs(100, 0, 50, 0, 3, 4);
      os_rst_wait = 1;
      run(16);

      // Long random run: random latency, redirects, ID back-pressure, idle acks.
      knobs(80, 5, 60, 10, 1, 4);
      run(800);

      knobs(0, 0, 100, 0, 1, 1);
      run(12);
      chk("pops_seen", 64'(n_pops >= 30), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
